// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame controller: register offsets,
// CTRL/STATUS bit positions and the frame state encoding.
// Pure package, no logic; no latency or backpressure of its own.
package sobel_pkg;

  // Register offsets (PADDR[7:0])
  localparam logic [7:0] ADDR_THRESH  = 8'h00;
  localparam logic [7:0] ADDR_WIDTH   = 8'h04;
  localparam logic [7:0] ADDR_HEIGHT  = 8'h08;
  localparam logic [7:0] ADDR_TOTAL   = 8'h0C;
  localparam logic [7:0] ADDR_KERNEL1 = 8'h10;
  localparam logic [7:0] ADDR_KERNEL2 = 8'h14;
  localparam logic [7:0] ADDR_KERNEL3 = 8'h18;
  localparam logic [7:0] ADDR_KERNEL4 = 8'h1C;
  localparam logic [7:0] ADDR_CTRL    = 8'h20;
  localparam logic [7:0] ADDR_STATUS  = 8'h24;
  localparam logic [7:0] ADDR_IN_CNT  = 8'h28;
  localparam logic [7:0] ADDR_OUT_CNT = 8'h2C;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_CFG_ERR  = 2;
  localparam int STAT_TIMEOUT  = 3;
  localparam int STAT_OVERFLOW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } frame_state_t;

endpackage

// File: rtl/sobel_apb_regs.sv
// APB register file for the Sobel frame controller: decode, config/CTRL/STATUS
// storage, start/abort pulse generation and PSLVERR.
// Writes commit in the access cycle; PRDATA is captured in the setup cycle.
// Never stalls the bus (PREADY is tied high at the top level).
module sobel_apb_regs
  import sobel_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  // APB slave
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [31:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PSLVERR,
  // Frame controller interface
  input  logic               busy,
  input  logic [CNT_W-1:0]   in_cnt,
  input  logic [CNT_W-1:0]   out_cnt,
  input  logic               done_set,
  input  logic               timeout_set,
  input  logic               overflow_set,
  output logic               start_pulse,
  output logic               abort_pulse,
  output logic               sobel_done,
  output logic               irq_en,
  // Configuration
  output logic [7:0]         cfg_threshold,
  output logic [DIM_W-1:0]   cfg_width,
  output logic [DIM_W-1:0]   cfg_height,
  output logic [31:0]        cfg_total,
  output logic [127:0]       cfg_kernel
);

  logic [7:0]       addr;
  logic             access;
  logic             wr;
  logic             mapped;
  logic             cfg_addr;
  logic [31:0]      rd_mux;
  logic             cfg_ok;
  logic             ctrl_wr;
  logic             start_req;
  logic             start_bad;
  logic             status_w1c;
  logic [3:0][31:0] kernel_r;
  logic             cfg_err_r;
  logic             timeout_r;
  logic             overflow_r;
  logic             unused_paddr;

  assign addr         = PADDR[7:0];
  assign unused_paddr = ^PADDR[31:8];
  assign access       = PSEL && PENABLE;
  assign wr           = access && PWRITE;
  assign cfg_kernel   = kernel_r;

  always_comb begin
    mapped   = 1'b1;
    cfg_addr = 1'b0;
    rd_mux   = '0;
    case (addr)
      ADDR_THRESH:  begin cfg_addr = 1'b1; rd_mux = {24'd0, cfg_threshold}; end
      ADDR_WIDTH:   begin cfg_addr = 1'b1; rd_mux = 32'(cfg_width);         end
      ADDR_HEIGHT:  begin cfg_addr = 1'b1; rd_mux = 32'(cfg_height);        end
      ADDR_TOTAL:   begin cfg_addr = 1'b1; rd_mux = cfg_total;              end
      ADDR_KERNEL1: begin cfg_addr = 1'b1; rd_mux = kernel_r[0];            end
      ADDR_KERNEL2: begin cfg_addr = 1'b1; rd_mux = kernel_r[1];            end
      ADDR_KERNEL3: begin cfg_addr = 1'b1; rd_mux = kernel_r[2];            end
      ADDR_KERNEL4: begin cfg_addr = 1'b1; rd_mux = kernel_r[3];            end
      // start/abort are self-clearing, so only irq_en reads back
      ADDR_CTRL:    rd_mux = {29'd0, irq_en, 2'b00};
      ADDR_STATUS:  rd_mux = {27'd0, overflow_r, timeout_r, cfg_err_r, sobel_done, busy};
      ADDR_IN_CNT:  rd_mux = 32'(in_cnt);
      ADDR_OUT_CNT: rd_mux = 32'(out_cnt);
      default:      mapped = 1'b0;
    endcase
  end

  // A frame must hold at least one full 3x3 window and TOTAL must agree
  // with the programmed geometry.
  assign cfg_ok = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3)) &&
                  (cfg_total == 32'(cfg_width) * 32'(cfg_height));

  assign ctrl_wr     = wr && (addr == ADDR_CTRL);
  assign status_w1c  = wr && (addr == ADDR_STATUS);
  // abort takes priority over a simultaneous start
  assign start_req   = ctrl_wr && PWDATA[CTRL_START] && !PWDATA[CTRL_ABORT];
  assign abort_pulse = ctrl_wr && PWDATA[CTRL_ABORT];
  assign start_pulse = start_req && !busy && cfg_ok;
  assign start_bad   = start_req && (busy || !cfg_ok);

  assign PSLVERR = access && (!mapped || (PWRITE && cfg_addr && busy) || start_bad);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_threshold <= '0;
      cfg_width     <= '0;
      cfg_height    <= '0;
      cfg_total     <= '0;
      kernel_r      <= '0;
      irq_en        <= 1'b0;
      sobel_done    <= 1'b0;
      cfg_err_r     <= 1'b0;
      timeout_r     <= 1'b0;
      overflow_r    <= 1'b0;
      PRDATA        <= '0;
    end else begin
      if (wr && !busy) begin
        case (addr)
          ADDR_THRESH: cfg_threshold <= PWDATA[7:0];
          ADDR_WIDTH:  cfg_width     <= PWDATA[DIM_W-1:0];
          ADDR_HEIGHT: cfg_height    <= PWDATA[DIM_W-1:0];
          ADDR_TOTAL:  cfg_total     <= PWDATA;
          ADDR_KERNEL1, ADDR_KERNEL2, ADDR_KERNEL3, ADDR_KERNEL4:
                       kernel_r[addr[3:2]] <= PWDATA;
          default: ;
        endcase
      end

      if (ctrl_wr) irq_en <= PWDATA[CTRL_IRQ_EN];

      // Sticky status: a set event in the same cycle beats a W1C.
      if (done_set)
        sobel_done <= 1'b1;
      else if (start_pulse || abort_pulse || (status_w1c && PWDATA[STAT_DONE]))
        sobel_done <= 1'b0;

      if (start_req && !busy && !cfg_ok)
        cfg_err_r <= 1'b1;
      else if (status_w1c && PWDATA[STAT_CFG_ERR])
        cfg_err_r <= 1'b0;

      if (timeout_set)
        timeout_r <= 1'b1;
      else if (status_w1c && PWDATA[STAT_TIMEOUT])
        timeout_r <= 1'b0;

      if (overflow_set)
        overflow_r <= 1'b1;
      else if (status_w1c && PWDATA[STAT_OVERFLOW])
        overflow_r <= 1'b0;

      if (PSEL && !PENABLE)
        PRDATA <= rd_mux;
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Sobel frame controller: APB config, frame FSM (IDLE/RUN/FLUSH/DONE),
// pixel row/col tracking with 3x3 window flag, and output counting.
// window_valid is one cycle after the accepted pixel; valid_in is never
// backpressured (pixels outside RUN are dropped and flagged as overflow).
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int DIM_W         = 16,
  parameter int CNT_W         = 32,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [31:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic               valid_in,
  input  logic               dp_valid_out,
  output logic [7:0]         cfg_threshold,
  output logic [DIM_W-1:0]   cfg_width,
  output logic [DIM_W-1:0]   cfg_height,
  output logic [127:0]       cfg_kernel,
  output logic               dp_run,
  output logic               frame_start,
  output logic [DIM_W-1:0]   pix_col,
  output logic [DIM_W-1:0]   pix_row,
  output logic               window_valid,
  output logic               sobel_done,
  output logic               irq
);

  localparam int PW    = 2 * DIM_W;
  localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);

  frame_state_t       state, state_nxt;
  logic               busy;
  logic               accept;
  logic               last_pix;
  logic               out_inc;
  logic               out_hit;
  logic               tmr_exp;
  logic               done_set;
  logic               timeout_set;
  logic               overflow_set;
  logic               start_pulse;
  logic               abort_pulse;
  logic               irq_en;
  logic [31:0]        cfg_total;
  logic [CNT_W-1:0]   in_cnt, in_cnt_inc;
  logic [CNT_W-1:0]   out_cnt, out_cnt_nxt;
  logic [PW-1:0]      exp_out;
  logic [DIM_W-1:0]   row, col;
  logic [TMR_W-1:0]   flush_tmr;

  sobel_apb_regs #(
    .DIM_W (DIM_W),
    .CNT_W (CNT_W)
  ) u_regs (
    .clk           (clk),
    .reset         (reset),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PSLVERR       (PSLVERR),
    .busy          (busy),
    .in_cnt        (in_cnt),
    .out_cnt       (out_cnt),
    .done_set      (done_set),
    .timeout_set   (timeout_set),
    .overflow_set  (overflow_set),
    .start_pulse   (start_pulse),
    .abort_pulse   (abort_pulse),
    .sobel_done    (sobel_done),
    .irq_en        (irq_en),
    .cfg_threshold (cfg_threshold),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_total     (cfg_total),
    .cfg_kernel    (cfg_kernel)
  );

  assign PREADY = 1'b1;
  assign busy   = (state == S_RUN) || (state == S_FLUSH);
  assign dp_run = busy;
  assign irq    = sobel_done && irq_en;

  assign accept       = valid_in && (state == S_RUN);
  assign overflow_set = valid_in && (state != S_RUN);
  assign in_cnt_inc   = in_cnt + CNT_W'(1);
  assign last_pix     = accept && (in_cnt_inc == CNT_W'(cfg_total));

  // Every interior pixel yields one datapath result.
  assign exp_out     = PW'(cfg_width - DIM_W'(2)) * PW'(cfg_height - DIM_W'(2));
  assign out_inc     = dp_valid_out && busy;
  assign out_cnt_nxt = out_cnt + CNT_W'(out_inc);
  // Uses the count including this cycle's strobe, so a result arriving
  // together with the last pixel can finish the frame straight from RUN.
  assign out_hit     = (out_cnt_nxt >= CNT_W'(exp_out));
  assign tmr_exp     = (state == S_FLUSH) && (flush_tmr == TMR_W'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_pulse) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort_pulse)   state_nxt = S_IDLE;
        else if (last_pix) state_nxt = out_hit ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        if (abort_pulse)  state_nxt = S_IDLE;
        else if (out_hit) state_nxt = S_DONE;
        else if (tmr_exp) begin
          state_nxt   = S_DONE;
          timeout_set = 1'b1;
        end
      end
      S_DONE: begin
        if (start_pulse)      state_nxt = S_RUN;
        else if (abort_pulse) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign done_set = (state_nxt == S_DONE) && (state != S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt       <= '0;
      out_cnt      <= '0;
      row          <= '0;
      col          <= '0;
      pix_row      <= '0;
      pix_col      <= '0;
      window_valid <= 1'b0;
      frame_start  <= 1'b0;
      flush_tmr    <= '0;
    end else begin
      frame_start <= start_pulse;
      flush_tmr   <= (state == S_FLUSH) ? flush_tmr + TMR_W'(1) : '0;

      if (start_pulse) begin
        in_cnt       <= '0;
        out_cnt      <= '0;
        row          <= '0;
        col          <= '0;
        window_valid <= 1'b0;
      end else begin
        if (out_inc) out_cnt <= out_cnt_nxt;

        if (accept) begin
          in_cnt <= in_cnt_inc;
          if (col == cfg_width - DIM_W'(1)) begin
            col <= '0;
            row <= row + DIM_W'(1);
          end else begin
            col <= col + DIM_W'(1);
          end
          // A 3x3 window is complete once two full rows and two columns
          // precede the current pixel; report its pre-increment position.
          window_valid <= (row >= DIM_W'(2)) && (col >= DIM_W'(2));
          pix_row      <= row;
          pix_col      <= col;
        end else begin
          window_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

  localparam int DIM_W = 16;
  localparam int CNT_W = 32;
  localparam int FLUSH_TIMEOUT = 1024;

  localparam logic [31:0] A_THRESH = 32'h00, A_WIDTH = 32'h04, A_HEIGHT = 32'h08,
                          A_TOTAL = 32'h0C, A_KERN1 = 32'h10, A_CTRL = 32'h20,
                          A_STATUS = 32'h24, A_IN_CNT = 32'h28, A_OUT_CNT = 32'h2C;

  logic             clk = 1'b0;
  logic             reset;
  logic             PSEL, PENABLE, PWRITE;
  logic [31:0]      PADDR, PWDATA, PRDATA;
  logic             PREADY, PSLVERR;
  logic             valid_in, dp_valid_out;
  logic [7:0]       cfg_threshold;
  logic [DIM_W-1:0] cfg_width, cfg_height;
  logic [127:0]     cfg_kernel;
  logic             dp_run, frame_start;
  logic [DIM_W-1:0] pix_col, pix_row;
  logic             window_valid, sobel_done, irq;

  int checks   = 0;
  int failures = 0;

  sobel_frame_ctrl #(
    .DIM_W(DIM_W), .CNT_W(CNT_W), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .valid_in(valid_in), .dp_valid_out(dp_valid_out),
    .cfg_threshold(cfg_threshold), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_kernel(cfg_kernel), .dp_run(dp_run), .frame_start(frame_start),
    .pix_col(pix_col), .pix_row(pix_row), .window_valid(window_valid),
    .sobel_done(sobel_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    d = PRDATA; err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(a, d, e);
    chk(tag, d, exp);
  endtask

  task automatic set_geom(input int w, input int h, input int total);
    logic e;
    apb_write(A_WIDTH, w, e);
    apb_write(A_HEIGHT, h, e);
    apb_write(A_TOTAL, total, e);
    chk("geom_wr_err", {31'd0, e}, 32'd0);
  endtask

  // Start with irq_en kept set; the frame must be running one cycle later.
  task automatic start_frame();
    logic e;
    apb_write(A_CTRL, 32'h5, e);
    chk("start_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("frame_start", {31'd0, frame_start}, 32'd1);
    chk("run_dp_run", {31'd0, dp_run}, 32'd1);
  endtask

  task automatic feed_pixels(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  // Streams a whole w x h frame with random gaps. The datapath model answers
  // each reported window one cycle later, but returns at most max_out results.
  // Expected window coordinates come from raster order: pixel k sits at
  // (k / w, k % w) and owns a window when both are >= 2.
  task automatic run_frame(input int w, input int h, input int max_out);
    logic [31:0] exp_q[$];
    logic [31:0] exp_c;
    int pix_left, pending, outs, n_win, n_exp, cycles;
    for (int k = 0; k < w * h; k++)
      if ((k / w) >= 2 && (k % w) >= 2)
        exp_q.push_back({16'(k / w), 16'(k % w)});
    n_exp = exp_q.size();
    pix_left = w * h; pending = 0; outs = 0; n_win = 0; cycles = 0;
    while (!sobel_done && cycles < 3000) begin
      @(posedge clk); #1;
      valid_in = (pix_left > 0) && ($urandom_range(0, 3) != 0);
      if (valid_in) pix_left--;
      dp_valid_out = (pending > 0) && (outs < max_out);
      if (dp_valid_out) begin pending--; outs++; end
      @(negedge clk);
      if (window_valid) begin
        n_win++;
        pending++;
        exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("win_coord", {pix_row, pix_col}, exp_c);
      end
      cycles++;
    end
    valid_in = 1'b0;
    dp_valid_out = 1'b0;
    chk("frame_finished", {31'd0, sobel_done}, 32'd1);
    chk("win_count", n_win, n_exp);
  endtask

  initial begin : main
    logic        e;
    logic [31:0] d;
    logic [31:0] kv[4];
    int          w, h;

    reset = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; valid_in = 1'b0; dp_valid_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pready", {31'd0, PREADY}, 32'd1);
    chk("rst_dp_run", {31'd0, dp_run}, 32'd0);
    chk("rst_done", {31'd0, sobel_done}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_win", {31'd0, window_valid}, 32'd0);
    chk("rst_width", 32'(cfg_width), 32'd0);
    chk("rst_fstart", {31'd0, frame_start}, 32'd0);
    reset = 1'b0;
    read_chk("rst_status", A_STATUS, 32'h0);

    // Configuration and readback
    apb_write(A_THRESH, 32'h3C, e);
    for (int i = 0; i < 4; i++) begin
      kv[i] = $urandom;
      apb_write(A_KERN1 + 32'(4 * i), kv[i], e);
    end
    for (int i = 0; i < 4; i++)
      chk("cfg_kernel", cfg_kernel[32*i +: 32], kv[i]);
    read_chk("kern3_rd", A_KERN1 + 32'h8, kv[2]);
    set_geom(5, 4, 20);
    read_chk("width_rd", A_WIDTH, 32'd5);
    chk("cfg_thresh", 32'(cfg_threshold), 32'h3C);

    // Normal 5x4 frame: 6 windows, 6 results
    start_frame();
    run_frame(5, 4, 6);
    chk("f1_irq", {31'd0, irq}, 32'd1);
    read_chk("f1_status", A_STATUS, 32'h2);
    read_chk("f1_in_cnt", A_IN_CNT, 32'd20);
    read_chk("f1_out_cnt", A_OUT_CNT, 32'd6);

    // Bad TOTAL: start rejected, cfg_err set, done untouched
    apb_write(A_TOTAL, 32'd19, e);
    apb_write(A_CTRL, 32'h5, e);
    chk("badcfg_slverr", {31'd0, e}, 32'd1);
    @(negedge clk);
    chk("badcfg_dp_run", {31'd0, dp_run}, 32'd0);
    read_chk("badcfg_status", A_STATUS, 32'h6);
    apb_write(A_STATUS, 32'h6, e);
    read_chk("w1c_status", A_STATUS, 32'h0);
    chk("w1c_irq", {31'd0, irq}, 32'd0);

    // Random geometry, config write during RUN is refused
    w = $urandom_range(3, 8);
    h = $urandom_range(3, 6);
    set_geom(w, h, w * h);
    start_frame();
    apb_write(A_THRESH, 32'h80, e);
    chk("busy_wr_slverr", {31'd0, e}, 32'd1);
    read_chk("busy_thresh_rd", A_THRESH, 32'h3C);
    chk("busy_cfg_thresh", 32'(cfg_threshold), 32'h3C);
    run_frame(w, h, (w - 2) * (h - 2));
    read_chk("rnd_in_cnt", A_IN_CNT, 32'(w * h));
    read_chk("rnd_out_cnt", A_OUT_CNT, 32'((w - 2) * (h - 2)));

    // Abort after 7 pixels
    set_geom(5, 4, 20);
    start_frame();
    feed_pixels(7);
    apb_write(A_CTRL, 32'h6, e);
    chk("abort_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("abort_dp_run", {31'd0, dp_run}, 32'd0);
    chk("abort_done", {31'd0, sobel_done}, 32'd0);
    read_chk("abort_in_cnt", A_IN_CNT, 32'd7);
    read_chk("abort_status", A_STATUS, 32'h0);

    // Start and abort together: abort wins, nothing starts
    apb_write(A_CTRL, 32'h7, e);
    chk("startabort_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("startabort_run", {31'd0, dp_run}, 32'd0);

    start_frame();
    run_frame(5, 4, 6);
    read_chk("rerun_in_cnt", A_IN_CNT, 32'd20);

    // Datapath short by one result: timeout path
    start_frame();
    chk("restart_done_clr", {31'd0, sobel_done}, 32'd0);
    run_frame(5, 4, 5);
    read_chk("tmo_status", A_STATUS, 32'hA);
    read_chk("tmo_out_cnt", A_OUT_CNT, 32'd5);

    // Pixel while DONE -> overflow; W1C done+overflow
    @(posedge clk); #1; valid_in = 1'b1;
    @(posedge clk); #1; valid_in = 1'b0;
    read_chk("ovf_status", A_STATUS, 32'h1A);
    apb_write(A_STATUS, 32'h12, e);
    @(negedge clk);
    chk("clr_done", {31'd0, sobel_done}, 32'd0);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    read_chk("clr_status", A_STATUS, 32'h8);

    // Unmapped access
    apb_read(32'h40, d, e);
    chk("unmap_rd_data", d, 32'h0);
    chk("unmap_rd_err", {31'd0, e}, 32'd1);
    apb_write(32'h30, 32'h1, e);
    chk("unmap_wr_err", {31'd0, e}, 32'd1);

    // Start while busy is refused; frame keeps running
    start_frame();
    apb_write(A_CTRL, 32'h5, e);
    chk("busy_start_err", {31'd0, e}, 32'd1);
    chk("busy_start_run", {31'd0, dp_run}, 32'd1);

    // Asynchronous reset mid-frame
    feed_pixels(3);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_dp_run", {31'd0, dp_run}, 32'd0);
    chk("arst_width", 32'(cfg_width), 32'd0);
    chk("arst_kernel", cfg_kernel[31:0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    read_chk("arst_in_cnt", A_IN_CNT, 32'd0);
    read_chk("arst_ctrl", A_CTRL, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
APB-programmed frame controller that configures and sequences the Sobel datapath. It holds the threshold, geometry and kernel registers and runs a frame state machine. It tracks row/column of every accepted input pixel and flags when a full 3x3 window is available. It counts datapath outputs to decide when the frame is complete. It sits between the APB bus and the line-buffer/convolution datapath inside sobel_top.

Parameters:
DIM_W, 16, width of width/height registers and row/col counters
CNT_W, 32, width of pixel/output counters
FLUSH_TIMEOUT, 1024, max cycles in FLUSH with no completion before forced DONE

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  32  APB address (bits [7:0] decoded)
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  always 1
PSLVERR  out  1  APB error, access phase only
valid_in  in  1  input pixel strobe (pixel itself goes straight to datapath)
dp_valid_out  in  1  datapath output strobe
cfg_threshold  out  8  THRESH[7:0]
cfg_width  out  DIM_W  image width
cfg_height  out  DIM_W  image height
cfg_kernel  out  128  {KERNEL4,KERNEL3,KERNEL2,KERNEL1}
dp_run  out  1  datapath enable (RUN or FLUSH)
frame_start  out  1  one-cycle pulse, datapath line-buffer clear
pix_col  out  DIM_W  column of pixel flagged by window_valid
pix_row  out  DIM_W  row of pixel flagged by window_valid
window_valid  out  1  3x3 window complete
sobel_done  out  1  frame complete, level
irq  out  1  sobel_done & CTRL.irq_en

Behaviour:
- Reset: all registers 0, state IDLE; all outputs 0 except PREADY=1.
- Register map: 0x00 THRESH, 0x04 WIDTH, 0x08 HEIGHT, 0x0C TOTAL, 0x10-0x1C KERNEL1-4, 0x20 CTRL (b0 start, self-clearing; b1 abort, self-clearing; b2 irq_en), 0x24 STATUS RO/W1C (b0 busy RO, b1 done W1C, b2 cfg_err W1C, b3 timeout W1C, b4 overflow W1C), 0x28 IN_CNT RO, 0x2C OUT_CNT RO. Unmapped address: read 0, PSLVERR=1.
- Write commits on cycle PSEL&PENABLE&PWRITE. PRDATA registered on setup cycle (PSEL&!PENABLE), valid during access.
- Config write (0x00-0x1C) while busy (RUN/FLUSH): ignored, PSLVERR=1.
- States IDLE, RUN, FLUSH, DONE.
- Start (IDLE or DONE): requires 3<=WIDTH, 3<=HEIGHT, TOTAL==WIDTH*HEIGHT. On failure: PSLVERR=1, cfg_err=1, state unchanged. On success: next cycle RUN, frame_start=1 for one cycle. Counters, row and col clear to 0; sobel_done clears.
- Start while busy: ignored, PSLVERR=1. Start and abort written together: abort wins, no start.
- RUN, each valid_in: IN_CNT++. col++; at col==WIDTH-1, col wraps to 0 and row++.
  - Registered: next cycle window_valid=1 with pix_row/pix_col = pre-increment row/col, if row>=2 && col>=2.
  - Accepting pixel TOTAL-1 (last) moves to FLUSH.
- dp_valid_out increments OUT_CNT in RUN and FLUSH.
- Expected output count is (WIDTH-2)*(HEIGHT-2). OUT_CNT reaching it, in FLUSH or on the last-pixel cycle, moves to DONE.
- FLUSH: timer counts cycles. Reaching FLUSH_TIMEOUT forces DONE with timeout=1.
- DONE: sobel_done=1 until next successful start, abort, or W1C of done.
- valid_in outside RUN: ignored, overflow=1 sticky.
- Abort in RUN/FLUSH: IDLE next cycle; sobel_done stays 0; counters hold for readback.
- dp_run=1 in RUN and FLUSH.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Decomposition:
- Package sobel_pkg: register offsets, STATUS/CTRL bit indices, state enum typedef.
- Sub-module sobel_apb_regs: APB decode, register storage, PSLVERR generation.
- sobel_frame_ctrl keeps the FSM, counters and window logic.

Test Plan:
- Normal 5x4 frame: WIDTH=5, HEIGHT=4, TOTAL=20, start, 20 valid_in; bench model returns 6 dp_valid_out -> window_valid pulses 6 times at (2,2),(2,3),(2,4),(3,2),(3,3),(3,4). Then sobel_done=1, STATUS=0x2, IN_CNT=20, OUT_CNT=6.
- Bad config TOTAL=19 with 5x4 -> start write gives PSLVERR=1; STATUS.cfg_err=1; state IDLE, dp_run=0.
- Write THRESH=0x80 during RUN -> PSLVERR=1; THRESH readback keeps old value.
- Abort after 7 pixels -> IDLE next cycle, sobel_done=0, IN_CNT=7. Start again completes normally.
- Datapath returns only 5 outputs -> DONE after FLUSH_TIMEOUT cycles; STATUS timeout=1, done=1.
- valid_in while in DONE -> overflow=1. Writing 0x12 to STATUS clears done and overflow; sobel_done=0, irq=0.
